// File: rtl/jtdd_gfxrom_if.sv
// ---------------------------------------------------------------------------
// jtdd_gfxrom_if
//   Memory-side read port between jtdd_gfxrom and the SDRAM controller.
//
//   mem_req   master->slave  read request, held until mem_rdy
//   mem_addr  master->slave  22-bit word address, stable while mem_req=1
//   mem_rdy   slave->master  one-cycle strobe: mem_data valid, request done
//   mem_data  slave->master  16-bit read word
// ---------------------------------------------------------------------------
interface jtdd_gfxrom_if;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_rdy;
    logic [15:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdy,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdy,
        output mem_data
    );
endinterface

// File: rtl/jtdd_gfxrom.sv
// ---------------------------------------------------------------------------
// jtdd_gfxrom
//   Graphics ROM responder for the Double Dragon video path. Serves the char
//   (8-bit), scroll (16-bit) and object (16-bit) fetch ports from a one-word
//   cache per port, and refills them through a single 16-bit memory read port
//   with a req/rdy handshake. Only one memory request is ever outstanding.
//
//   Ports:
//     clk, rst               clock; asynchronous active-high reset
//     char_addr/data/ok      char byte address, byte, valid flag
//     scr_addr/data/ok       scroll word address, word, valid flag
//     obj_addr/data/ok       object word address, word, valid flag
//     mem (master modport)   mem_req/mem_addr out, mem_rdy/mem_data in
//
//   Parameters: CHAR_OFFSET, SCR_OFFSET, OBJ_OFFSET - word offsets of each
//   ROM region in memory (address sum wraps modulo 2^22).
//
//   Build option: JTDD_GFXROM_OBJPRIO_EN selects fixed priority
//   obj > scr > char. Without it, ports are served round-robin
//   char -> scr -> obj -> char, starting after the last-served port.
// ---------------------------------------------------------------------------
module jtdd_gfxrom #(
    parameter logic [21:0] CHAR_OFFSET = 22'h00000,
    parameter logic [21:0] SCR_OFFSET  = 22'h08000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h28000
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [15:0]          char_addr,
    output logic [7:0]           char_data,
    output logic                 char_ok,

    input  logic [16:0]          scr_addr,
    output logic [15:0]          scr_data,
    output logic                 scr_ok,

    input  logic [18:0]          obj_addr,
    output logic [15:0]          obj_data,
    output logic                 obj_ok,

    jtdd_gfxrom_if.master        mem
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        PORT_CHAR,
        PORT_SCR,
        PORT_OBJ
    } port_t;

    // FSM and request registers
    state_t      state_q,    state_d;
    port_t       win_q,      win_d;
    logic [18:0] pend_tag_q, pend_tag_d;
    logic        req_q,      req_d;
    logic [21:0] addr_q,     addr_d;

`ifndef JTDD_GFXROM_OBJPRIO_EN
    port_t       last_q,     last_d;
`endif

    // Per-port cache: tag, valid, data
    logic [14:0] char_tag_q, char_tag_d;
    logic        char_vld_q, char_vld_d;
    logic [15:0] char_dat_q, char_dat_d;

    logic [16:0] scr_tag_q,  scr_tag_d;
    logic        scr_vld_q,  scr_vld_d;
    logic [15:0] scr_dat_q,  scr_dat_d;

    logic [18:0] obj_tag_q,  obj_tag_d;
    logic        obj_vld_q,  obj_vld_d;
    logic [15:0] obj_dat_q,  obj_dat_d;

    // Combinational port status
    logic        char_pend, scr_pend, obj_pend, any_pend;
    logic [21:0] char_maddr, scr_maddr, obj_maddr;
    port_t       grant;

    // ok drops in the same cycle the address moves off the stored tag
    assign char_ok   = char_vld_q && (char_addr[15:1] == char_tag_q);
    assign scr_ok    = scr_vld_q  && (scr_addr        == scr_tag_q);
    assign obj_ok    = obj_vld_q  && (obj_addr        == obj_tag_q);

    assign char_pend = !char_ok;
    assign scr_pend  = !scr_ok;
    assign obj_pend  = !obj_ok;
    assign any_pend  = char_pend || scr_pend || obj_pend;

    // One fetch serves both bytes of a char word
    assign char_data = char_addr[0] ? char_dat_q[15:8] : char_dat_q[7:0];
    assign scr_data  = scr_dat_q;
    assign obj_data  = obj_dat_q;

    assign char_maddr = CHAR_OFFSET + {7'd0, char_addr[15:1]};
    assign scr_maddr  = SCR_OFFSET  + {5'd0, scr_addr};
    assign obj_maddr  = OBJ_OFFSET  + {3'd0, obj_addr};

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;

    // Arbitration: only meaningful when any_pend is set
    always_comb begin
        grant = PORT_CHAR;
`ifdef JTDD_GFXROM_OBJPRIO_EN
        if (obj_pend)       grant = PORT_OBJ;
        else if (scr_pend)  grant = PORT_SCR;
        else                grant = PORT_CHAR;
`else
        // Search begins with the port after the one served last
        case (last_q)
            PORT_CHAR: begin
                if (scr_pend)       grant = PORT_SCR;
                else if (obj_pend)  grant = PORT_OBJ;
                else                grant = PORT_CHAR;
            end
            PORT_SCR: begin
                if (obj_pend)       grant = PORT_OBJ;
                else if (char_pend) grant = PORT_CHAR;
                else                grant = PORT_SCR;
            end
            default: begin
                if (char_pend)      grant = PORT_CHAR;
                else if (scr_pend)  grant = PORT_SCR;
                else                grant = PORT_OBJ;
            end
        endcase
`endif
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        pend_tag_d = pend_tag_q;
        req_d      = req_q;
        addr_d     = addr_q;
`ifndef JTDD_GFXROM_OBJPRIO_EN
        last_d     = last_q;
`endif
        char_tag_d = char_tag_q;
        char_vld_d = char_vld_q;
        char_dat_d = char_dat_q;
        scr_tag_d  = scr_tag_q;
        scr_vld_d  = scr_vld_q;
        scr_dat_d  = scr_dat_q;
        obj_tag_d  = obj_tag_q;
        obj_vld_d  = obj_vld_q;
        obj_dat_d  = obj_dat_q;

        case (state_q)
            ST_IDLE: begin
                // mem_rdy is deliberately not looked at here
                if (any_pend) begin
                    win_d   = grant;
`ifndef JTDD_GFXROM_OBJPRIO_EN
                    last_d  = grant;
`endif
                    req_d   = 1'b1;
                    state_d = ST_WAIT;
                    case (grant)
                        PORT_CHAR: begin
                            pend_tag_d = {4'd0, char_addr[15:1]};
                            addr_d     = char_maddr;
                        end
                        PORT_SCR: begin
                            pend_tag_d = {2'd0, scr_addr};
                            addr_d     = scr_maddr;
                        end
                        default: begin
                            pend_tag_d = obj_addr;
                            addr_d     = obj_maddr;
                        end
                    endcase
                end
            end

            ST_WAIT: begin
                // The snapshot tag is stored even if the port address has
                // since moved; the port then stays pending and re-requests.
                if (mem.mem_rdy) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                    case (win_q)
                        PORT_CHAR: begin
                            char_tag_d = pend_tag_q[14:0];
                            char_dat_d = mem.mem_data;
                            char_vld_d = 1'b1;
                        end
                        PORT_SCR: begin
                            scr_tag_d  = pend_tag_q[16:0];
                            scr_dat_d  = mem.mem_data;
                            scr_vld_d  = 1'b1;
                        end
                        default: begin
                            obj_tag_d  = pend_tag_q;
                            obj_dat_d  = mem.mem_data;
                            obj_vld_d  = 1'b1;
                        end
                    endcase
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            win_q      <= PORT_CHAR;
            pend_tag_q <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
`ifndef JTDD_GFXROM_OBJPRIO_EN
            last_q     <= PORT_OBJ;
`endif
            char_tag_q <= '0;
            char_vld_q <= 1'b0;
            char_dat_q <= '0;
            scr_tag_q  <= '0;
            scr_vld_q  <= 1'b0;
            scr_dat_q  <= '0;
            obj_tag_q  <= '0;
            obj_vld_q  <= 1'b0;
            obj_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            pend_tag_q <= pend_tag_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
`ifndef JTDD_GFXROM_OBJPRIO_EN
            last_q     <= last_d;
`endif
            char_tag_q <= char_tag_d;
            char_vld_q <= char_vld_d;
            char_dat_q <= char_dat_d;
            scr_tag_q  <= scr_tag_d;
            scr_vld_q  <= scr_vld_d;
            scr_dat_q  <= scr_dat_d;
            obj_tag_q  <= obj_tag_d;
            obj_vld_q  <= obj_vld_d;
            obj_dat_q  <= obj_dat_d;
        end
    end

endmodule

// File: tb/tb_jtdd_gfxrom.sv
// ---------------------------------------------------------------------------
// tb_jtdd_gfxrom
//   Self-checking bench for jtdd_gfxrom. A memory responder answers requests
//   after a programmable latency and checks each request address against a
//   queue of expected addresses. Honours JTDD_GFXROM_OBJPRIO_EN for the
//   expected grant order.
// ---------------------------------------------------------------------------
module tb_jtdd_gfxrom;

    localparam logic [21:0] CHAR_OFF = 22'h000000;
    localparam logic [21:0] SCR_OFF  = 22'h008000;
    localparam logic [21:0] OBJ_OFF  = 22'h3C0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] char_addr = '0;
    logic [7:0]  char_data;
    logic        char_ok;
    logic [16:0] scr_addr = '0;
    logic [15:0] scr_data;
    logic        scr_ok;
    logic [18:0] obj_addr = '0;
    logic [15:0] obj_data;
    logic        obj_ok;

    jtdd_gfxrom_if mem_bus ();

    jtdd_gfxrom #(
        .CHAR_OFFSET (CHAR_OFF),
        .SCR_OFFSET  (SCR_OFF),
        .OBJ_OFFSET  (OBJ_OFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .char_addr (char_addr),
        .char_data (char_data),
        .char_ok   (char_ok),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .scr_ok    (scr_ok),
        .obj_addr  (obj_addr),
        .obj_data  (obj_data),
        .obj_ok    (obj_ok),
        .mem       (mem_bus.master)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned n_req  = 0;

    logic [21:0] exp_q[$];

    // responder controls
    logic        auto_en  = 1'b1;
    int unsigned lat      = 1;
    logic        man_rdy  = 1'b0;
    logic [15:0] man_data = '0;

    function automatic logic [15:0] data_of(input logic [21:0] a);
        if (a == 22'h000001) return 16'hA55A;
        return a[15:0] ^ 16'h3C96 ^ {10'd0, a[21:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: sole driver of mem_rdy/mem_data
    initial begin
        logic        req_seen;
        logic        fire;
        int unsigned cnt;
        logic [21:0] cur_addr;
        logic [21:0] e;
        req_seen = 1'b0;
        cnt      = 0;
        cur_addr = '0;
        mem_bus.mem_rdy  = 1'b0;
        mem_bus.mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            fire = 1'b0;
            if (!mem_bus.mem_req) begin
                req_seen = 1'b0;
            end else if (!req_seen) begin
                req_seen = 1'b1;
                cnt      = 0;
                cur_addr = mem_bus.mem_addr;
                n_req++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_req: mem_addr=%h, none expected", mem_bus.mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("req_addr", 32'(mem_bus.mem_addr), 32'(e));
                end
            end else begin
                cnt++;
                check("addr_stable", 32'(mem_bus.mem_addr), 32'(cur_addr));
            end
            if (req_seen && auto_en && cnt >= lat) begin
                fire     = 1'b1;
                req_seen = 1'b0;
            end
            mem_bus.mem_rdy  = fire || man_rdy;
            mem_bus.mem_data = fire ? data_of(cur_addr) : man_data;
        end
    end

    task automatic wait_all_ok(input int unsigned lim, input string name);
        int unsigned n = 0;
        while (!(char_ok && scr_ok && obj_ok) && n < lim) begin
            step();
            n++;
        end
        check(name, 32'(char_ok && scr_ok && obj_ok), 32'd1);
    endtask

    task automatic wait_req(input logic lvl, input int unsigned lim, input string name);
        int unsigned n = 0;
        while (mem_bus.mem_req !== lvl && n < lim) begin
            step();
            n++;
        end
        check(name, 32'(mem_bus.mem_req), 32'(lvl));
    endtask

    task automatic check_queue_empty(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [15:0] c;
        logic [16:0] s;
        logic [18:0] o;
        logic        c_ok;
        logic [7:0]  c_dat;
        logic        s_ok;
        logic [15:0] s_dat;
        logic        o_ok;
        logic [15:0] o_dat;
    } vec_t;

    vec_t tbl[8];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sd, od, cd;
        int unsigned nreq0;

        sd = data_of(SCR_OFF + 22'h100);
        od = data_of(OBJ_OFF + 22'h10);
        tbl[0] = '{16'h0003, 17'h00100, 19'h00010, 1'b1, 8'hA5, 1'b1, sd, 1'b1, od};
        tbl[1] = '{16'h0002, 17'h00100, 19'h00010, 1'b1, 8'h5A, 1'b1, sd, 1'b1, od};
        tbl[2] = '{16'h0004, 17'h00100, 19'h00010, 1'b0, 8'h00, 1'b1, sd, 1'b1, od};
        tbl[3] = '{16'h0001, 17'h00100, 19'h00010, 1'b0, 8'h00, 1'b1, sd, 1'b1, od};
        tbl[4] = '{16'h0003, 17'h00101, 19'h00010, 1'b1, 8'hA5, 1'b0, 16'h0, 1'b1, od};
        tbl[5] = '{16'h0003, 17'h00100, 19'h00011, 1'b1, 8'hA5, 1'b1, sd, 1'b0, 16'h0};
        tbl[6] = '{16'h0002, 17'h00000, 19'h00000, 1'b1, 8'h5A, 1'b0, 16'h0, 1'b0, 16'h0};
        tbl[7] = '{16'h0005, 17'h00100, 19'h00090, 1'b0, 8'h00, 1'b1, sd, 1'b0, 16'h0};

        // ---------------- Test 1: reset and first char fetch ----------------
        lat = 1;
        char_addr = 16'h0003;
        scr_addr  = 17'h00100;
        obj_addr  = 19'h00010;
        step();
        step();
        check("rst_mem_req",  32'(mem_bus.mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("rst_oks",      32'({char_ok, scr_ok, obj_ok}), 32'd0);
        check("rst_scr_data", 32'(scr_data), 32'd0);
`ifdef JTDD_GFXROM_OBJPRIO_EN
        exp_q.push_back(OBJ_OFF + 22'h10);
        exp_q.push_back(SCR_OFF + 22'h100);
        exp_q.push_back(22'h000001);
`else
        exp_q.push_back(22'h000001);
        exp_q.push_back(SCR_OFF + 22'h100);
        exp_q.push_back(OBJ_OFF + 22'h10);
`endif
        rst = 1'b0;                                 // cycle 0 follows
        step();                                     // cycle 1
        check("t1_req_c1", 32'(mem_bus.mem_req), 32'd1);
`ifdef JTDD_GFXROM_OBJPRIO_EN
        check("t1_addr_c1", 32'(mem_bus.mem_addr), 32'(OBJ_OFF + 22'h10));
`else
        check("t1_addr_c1", 32'(mem_bus.mem_addr), 32'h000001);
        check("t1_char_ok_c1", 32'(char_ok), 32'd0);
`endif
        step();                                     // cycle 2
        step();                                     // cycle 3
`ifdef JTDD_GFXROM_OBJPRIO_EN
        check("t1_obj_ok_c3",   32'(obj_ok), 32'd1);
        check("t1_obj_data_c3", 32'(obj_data), 32'(od));
`else
        check("t1_char_ok_c3",   32'(char_ok), 32'd1);
        check("t1_char_data_c3", 32'(char_data), 32'hA5);
`endif
        check("t1_req_gap", 32'(mem_bus.mem_req), 32'd0);
        wait_all_ok(60, "t1_all_ok");
        check_queue_empty("t1_queue");
        nreq0 = n_req;
        char_addr = 16'h0002;
        #1;
        check("t1_char_ok_odd", 32'(char_ok), 32'd1);
        check("t1_char_data_lo", 32'(char_data), 32'h5A);
        for (int unsigned i = 0; i < 6; i++) step();
        check("t1_no_new_req", n_req, nreq0);

        // ---------------- Table: combinational ok/data ----------------
        for (int unsigned i = 0; i < 8; i++) begin
            step();
            char_addr = tbl[i].c;
            scr_addr  = tbl[i].s;
            obj_addr  = tbl[i].o;
            #1;
            check("tbl_char_ok", 32'(char_ok), 32'(tbl[i].c_ok));
            check("tbl_scr_ok",  32'(scr_ok),  32'(tbl[i].s_ok));
            check("tbl_obj_ok",  32'(obj_ok),  32'(tbl[i].o_ok));
            if (tbl[i].c_ok) check("tbl_char_data", 32'(char_data), 32'(tbl[i].c_dat));
            if (tbl[i].s_ok) check("tbl_scr_data",  32'(scr_data),  32'(tbl[i].s_dat));
            if (tbl[i].o_ok) check("tbl_obj_data",  32'(obj_data),  32'(tbl[i].o_dat));
            char_addr = 16'h0003;
            scr_addr  = 17'h00100;
            obj_addr  = 19'h00010;
        end
        step();
        check("tbl_no_req", n_req, nreq0);

        // ---------------- Test 2: grant order, latency 2 ----------------
        lat = 2;
        rst = 1'b1;
        char_addr = 16'h0100;
        scr_addr  = 17'h1ABCD;
        obj_addr  = 19'h00010;
`ifdef JTDD_GFXROM_OBJPRIO_EN
        exp_q.push_back(OBJ_OFF + 22'h10);
        exp_q.push_back(SCR_OFF + 22'h1ABCD);
        exp_q.push_back(CHAR_OFF + 22'h80);
`else
        exp_q.push_back(CHAR_OFF + 22'h80);
        exp_q.push_back(SCR_OFF + 22'h1ABCD);
        exp_q.push_back(OBJ_OFF + 22'h10);
`endif
        step();
        rst = 1'b0;
        wait_all_ok(80, "t2_all_ok");
        check_queue_empty("t2_queue");
        cd = data_of(CHAR_OFF + 22'h80);
        check("t2_char_data", 32'(char_data), 32'(cd[7:0]));
        check("t2_scr_data",  32'(scr_data),  32'(data_of(SCR_OFF + 22'h1ABCD)));
        check("t2_obj_data",  32'(obj_data),  32'(data_of(OBJ_OFF + 22'h10)));

        // ---------------- Test 3: obj address moves during WAIT ----------------
        rst = 1'b1;
        char_addr = 16'h0010;
        scr_addr  = 17'h00020;
        obj_addr  = 19'h00010;
`ifdef JTDD_GFXROM_OBJPRIO_EN
        exp_q.push_back(OBJ_OFF + 22'h10);
        exp_q.push_back(OBJ_OFF + 22'h20);
        exp_q.push_back(SCR_OFF + 22'h20);
        exp_q.push_back(CHAR_OFF + 22'h08);
`else
        exp_q.push_back(CHAR_OFF + 22'h08);
        exp_q.push_back(SCR_OFF + 22'h20);
        exp_q.push_back(OBJ_OFF + 22'h10);
        exp_q.push_back(OBJ_OFF + 22'h20);
`endif
        step();
        rst = 1'b0;
        begin
            int unsigned n = 0;
            while (!(mem_bus.mem_req && mem_bus.mem_addr == OBJ_OFF + 22'h10) && n < 60) begin
                step();
                n++;
            end
            check("t3_obj_req_seen", 32'(mem_bus.mem_req), 32'd1);
        end
        obj_addr = 19'h00020;
        wait_req(1'b0, 20, "t3_first_done");
        check("t3_obj_ok_stale", 32'(obj_ok), 32'd0);
        wait_req(1'b1, 20, "t3_rereq");
        check("t3_rereq_addr", 32'(mem_bus.mem_addr), 32'(OBJ_OFF + 22'h20));
        check("t3_obj_ok_wait", 32'(obj_ok), 32'd0);
        wait_all_ok(60, "t3_all_ok");
        check("t3_obj_data", 32'(obj_data), 32'(data_of(OBJ_OFF + 22'h20)));
        check_queue_empty("t3_queue");

        // ---------------- Test 4: reset mid-WAIT, stray mem_rdy ----------------
        auto_en = 1'b0;
        exp_q.push_back(CHAR_OFF + 22'h20);
        char_addr = 16'h0040;
        wait_req(1'b1, 10, "t4_req");
        step();
        rst      = 1'b1;
        man_rdy  = 1'b1;
        man_data = 16'hDEAD;
        #1;
        check("t4_rst_req",  32'(mem_bus.mem_req), 32'd0);
        check("t4_rst_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("t4_rst_oks",  32'({char_ok, scr_ok, obj_ok}), 32'd0);
`ifdef JTDD_GFXROM_OBJPRIO_EN
        exp_q.push_back(OBJ_OFF + 22'h20);
        exp_q.push_back(SCR_OFF + 22'h20);
        exp_q.push_back(CHAR_OFF + 22'h20);
`else
        exp_q.push_back(CHAR_OFF + 22'h20);
        exp_q.push_back(SCR_OFF + 22'h20);
        exp_q.push_back(OBJ_OFF + 22'h20);
`endif
        step();
        rst     = 1'b0;
        man_rdy = 1'b0;
        step();                                     // stray mem_rdy seen in IDLE
        check("t4_stray_oks",  32'({char_ok, scr_ok, obj_ok}), 32'd0);
        check("t4_stray_char", 32'(char_data), 32'd0);
        check("t4_stray_scr",  32'(scr_data), 32'd0);
        check("t4_stray_obj",  32'(obj_data), 32'd0);
        check("t4_new_req",    32'(mem_bus.mem_req), 32'd1);
        auto_en = 1'b1;
        wait_all_ok(80, "t4_all_ok");
        cd = data_of(CHAR_OFF + 22'h20);
        check("t4_char_data", 32'(char_data), 32'(cd[7:0]));
        check("t4_scr_data",  32'(scr_data),  32'(data_of(SCR_OFF + 22'h20)));
        check_queue_empty("t4_queue");

        // ---------------- Test 5: unsolicited mem_rdy, address wrap ----------------
        auto_en  = 1'b0;
        nreq0    = n_req;
        man_rdy  = 1'b1;
        man_data = 16'hBEEF;
        step();
        man_rdy  = 1'b0;
        step();
        step();
        check("t5_oks",      32'({char_ok, scr_ok, obj_ok}), 32'h7);
        check("t5_char",     32'(char_data), 32'(cd[7:0]));
        check("t5_scr",      32'(scr_data),  32'(data_of(SCR_OFF + 22'h20)));
        check("t5_obj",      32'(obj_data),  32'(data_of(OBJ_OFF + 22'h20)));
        check("t5_no_req",   n_req, nreq0);
        auto_en = 1'b1;
        exp_q.push_back(22'h03FFFF);
        obj_addr = 19'h7FFFF;
        #1;
        check("t5_obj_pending", 32'(obj_ok), 32'd0);
        wait_req(1'b1, 10, "t5_wrap_req");
        check("t5_wrap_addr", 32'(mem_bus.mem_addr), 32'h03FFFF);
        wait_all_ok(40, "t5_all_ok");
        od = data_of(22'h03FFFF);
        check("t5_wrap_data", 32'(obj_data), 32'(od));
        check_queue_empty("t5_queue");

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
